// File: rtl/led_pkg.sv
// Shared encodings for the LED sequencer: CPU register map, animation modes,
// ownership states, and 16-bit rotate helpers used by the shift modes.
package led_pkg;

    // CPU register map (address 3 is reserved and ignored)
    localparam logic [1:0] ADDR_PATTERN = 2'd0;
    localparam logic [1:0] ADDR_MODE    = 2'd1;
    localparam logic [1:0] ADDR_DIV     = 2'd2;

    typedef enum logic [1:0] {
        MODE_STATIC  = 2'd0,
        MODE_BLINK   = 2'd1,
        MODE_SHIFT_L = 2'd2,
        MODE_SHIFT_R = 2'd3
    } mode_e;

    typedef enum logic {
        ST_ANIM = 1'b0,
        ST_HW   = 1'b1
    } state_e;

    function automatic logic [15:0] rotl16(input logic [15:0] v);
        return {v[14:0], v[15]};
    endfunction

    function automatic logic [15:0] rotr16(input logic [15:0] v);
        return {v[0], v[15:1]};
    endfunction

endpackage

// File: rtl/led_sequencer_if.sv
// Signal bundle for the LED sequencer: CPU register-write bus, hardware
// requester handshake, and the LED register write port.
//   master : drives cpu_*, hw_req, hw_pattern; observes hw_gnt and led_*
//   slave  : the sequencer side
interface led_sequencer_if #(
    parameter int Dbits = 32
);
    logic             cpu_wr;
    logic [1:0]       cpu_addr;
    logic [Dbits-1:0] cpu_writedata;
    logic             hw_req;
    logic [15:0]      hw_pattern;
    logic             hw_gnt;
    logic             led_wr;
    logic [Dbits-1:0] led_writedata;

    modport master (
        output cpu_wr, cpu_addr, cpu_writedata, hw_req, hw_pattern,
        input  hw_gnt, led_wr, led_writedata
    );

    modport slave (
        input  cpu_wr, cpu_addr, cpu_writedata, hw_req, hw_pattern,
        output hw_gnt, led_wr, led_writedata
    );
endinterface

// File: rtl/led_prescaler.sv
// Reloadable down-counter setting the animation rate.
//   clock, reset_n : clock, async active-low reset (count -> 0)
//   reload         : load div immediately (suppresses the countdown)
//   div            : reload value; period between ticks is div+1 cycles
//   tick           : high while the count sits at 0
module led_prescaler #(
    parameter int DIV_W = 26
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             reload,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);
    logic [DIV_W-1:0] count;

    assign tick = (count == '0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            count <= '0;
        else if (reload || tick)
            count <= div;
        else
            count <= count - 1'b1;
    end
endmodule

// File: rtl/led_sequencer.sv
// LED sequencer: CPU-programmed animation (static/blink/rotate) with a
// hardware requester that can take over the LEDs while hw_req is high.
//   clock, reset_n            : clock, async active-low reset
//   cpu_wr/addr/writedata     : register writes (PATTERN, MODE, DIV)
//   hw_req, hw_pattern        : hardware requester and its LED value
//   hw_gnt                    : high while the requester owns the LEDs
//   led_wr, led_writedata     : one-cycle LED register write, upper bits 0
module led_sequencer
    import led_pkg::*;
#(
    parameter int Dbits = 32,
    parameter int DIV_W = 26
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             cpu_wr,
    input  logic [1:0]       cpu_addr,
    input  logic [Dbits-1:0] cpu_writedata,
    input  logic             hw_req,
    input  logic [15:0]      hw_pattern,
    output logic             hw_gnt,
    output logic             led_wr,
    output logic [Dbits-1:0] led_writedata
);
    state_e           state_q, state_d;
    mode_e            mode_q, mode_d;
    logic [15:0]      pattern_q, pattern_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [15:0]      cur_q, cur_d;
    logic [15:0]      data_q, data_d;
    logic             wr_q, wr_d;
    logic             phase_q, phase_d;   // blink: 1 = LEDs currently dark
    logic             reload, tick;
    logic             pat_wr, mode_wr, div_wr;
    logic             unused_bits;

    assign unused_bits = ^cpu_writedata;

    assign pat_wr  = cpu_wr && (cpu_addr == ADDR_PATTERN);
    assign mode_wr = cpu_wr && (cpu_addr == ADDR_MODE);
    assign div_wr  = cpu_wr && (cpu_addr == ADDR_DIV);

    assign hw_gnt        = (state_q == ST_HW);
    assign led_wr        = wr_q;
    assign led_writedata = Dbits'(data_q);

    // Reload takes the new DIV so a DIV write sets the period right away
    led_prescaler #(.DIV_W(DIV_W)) u_prescaler (
        .clock   (clock),
        .reset_n (reset_n),
        .reload  (reload),
        .div     (div_d),
        .tick    (tick)
    );

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        pattern_d = pattern_q;
        div_d     = div_q;
        cur_d     = cur_q;
        data_d    = data_q;
        wr_d      = 1'b0;
        phase_d   = phase_q;
        reload    = 1'b0;

        // Register writes land in any state
        if (pat_wr)  pattern_d = cpu_writedata[15:0];
        if (mode_wr) mode_d    = mode_e'(cpu_writedata[1:0]);
        if (div_wr)  div_d     = DIV_W'(cpu_writedata);
        if (pat_wr || mode_wr || div_wr) begin
            reload  = 1'b1;
            phase_d = 1'b0;
        end

        case (state_q)
            ST_ANIM: begin
                if (hw_req) begin
                    // Requester wins over any CPU write or tick this cycle
                    state_d = ST_HW;
                    cur_d   = hw_pattern;
                    data_d  = hw_pattern;
                    wr_d    = 1'b1;
                    reload  = 1'b1;
                end else if (pat_wr || mode_wr) begin
                    cur_d  = pattern_d;
                    data_d = pattern_d;
                    wr_d   = 1'b1;
                end else if (tick && !div_wr) begin
                    case (mode_q)
                        MODE_BLINK: begin
                            phase_d = !phase_q;
                            data_d  = phase_q ? cur_q : 16'h0000;
                            wr_d    = 1'b1;
                        end
                        MODE_SHIFT_L: begin
                            cur_d  = rotl16(cur_q);
                            data_d = rotl16(cur_q);
                            wr_d   = 1'b1;
                        end
                        MODE_SHIFT_R: begin
                            cur_d  = rotr16(cur_q);
                            data_d = rotr16(cur_q);
                            wr_d   = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            ST_HW: begin
                reload = 1'b1;
                if (!hw_req) begin
                    state_d = ST_ANIM;
                    cur_d   = pattern_d;
                    data_d  = pattern_d;
                    wr_d    = 1'b1;
                    phase_d = 1'b0;
                end else if (hw_pattern != cur_q) begin
                    cur_d  = hw_pattern;
                    data_d = hw_pattern;
                    wr_d   = 1'b1;
                end
            end
            default: state_d = ST_ANIM;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_ANIM;
            mode_q    <= MODE_STATIC;
            pattern_q <= '0;
            div_q     <= '0;
            cur_q     <= '0;
            data_q    <= '0;
            wr_q      <= 1'b0;
            phase_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            pattern_q <= pattern_d;
            div_q     <= div_d;
            cur_q     <= cur_d;
            data_q    <= data_d;
            wr_q      <= wr_d;
            phase_q   <= phase_d;
        end
    end
endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer: a vector table for single-cycle
// behaviour plus hand-written multi-cycle sequences (timing of animation
// pulses, priority, async reset).
module tb_led_sequencer;
    import led_pkg::*;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;
    bit   rec = 1'b0;
    int   cw;

    typedef struct {
        logic [31:0] d;
        int          c;
    } pulse_t;
    pulse_t pq[$];

    typedef struct {
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic        hreq;
        logic [15:0] hpat;
        logic        ewr;
        logic [31:0] edata;
        logic        egnt;
    } vec_t;
    vec_t vecs[17];

    led_sequencer_if #(.Dbits(32)) bus ();

    led_sequencer #(.Dbits(32), .DIV_W(26)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .cpu_wr        (bus.cpu_wr),
        .cpu_addr      (bus.cpu_addr),
        .cpu_writedata (bus.cpu_writedata),
        .hw_req        (bus.hw_req),
        .hw_pattern    (bus.hw_pattern),
        .hw_gnt        (bus.hw_gnt),
        .led_wr        (bus.led_wr),
        .led_writedata (bus.led_writedata)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock)
        if (rec && bus.led_wr === 1'b1)
            pq.push_back(pulse_t'{d: bus.led_writedata, c: cyc});

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] pd(input int i);
        return (i < pq.size()) ? pq[i].d : 32'hxxxx_xxxx;
    endfunction

    function automatic int pc(input int i);
        return (i < pq.size()) ? pq[i].c : -1000;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic cpu_write(input logic [1:0] a, input logic [31:0] d);
        bus.cpu_wr = 1'b1;
        bus.cpu_addr = a;
        bus.cpu_writedata = d;
        @(posedge clock);
        #1;
        bus.cpu_wr = 1'b0;
    endtask

    task automatic do_reset();
        bus.cpu_wr = 1'b0;
        bus.cpu_addr = 2'd0;
        bus.cpu_writedata = '0;
        bus.hw_req = 1'b0;
        bus.hw_pattern = '0;
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock) reset_n = 1'b1;
        idle(1);
    endtask

    initial begin
        // addr wdata hreq hpat -> led_wr led_writedata hw_gnt
        vecs[0]  = '{1'b0, 2'd0, 32'h0,    1'b0, 16'h0,    1'b0, 32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b1, 2'd0, 32'hA5A5, 1'b0, 16'h0,    1'b1, 32'h0000_A5A5, 1'b0};
        vecs[2]  = '{1'b0, 2'd0, 32'h0,    1'b0, 16'h0,    1'b0, 32'h0000_A5A5, 1'b0};
        vecs[3]  = '{1'b1, 2'd3, 32'hFFFF, 1'b0, 16'h0,    1'b0, 32'h0000_A5A5, 1'b0};
        vecs[4]  = '{1'b0, 2'd0, 32'h0,    1'b0, 16'h0,    1'b0, 32'h0000_A5A5, 1'b0};
        vecs[5]  = '{1'b1, 2'd1, 32'h3,    1'b0, 16'h0,    1'b1, 32'h0000_A5A5, 1'b0};
        vecs[6]  = '{1'b0, 2'd0, 32'h0,    1'b0, 16'h0,    1'b1, 32'h0000_D2D2, 1'b0};
        vecs[7]  = '{1'b0, 2'd0, 32'h0,    1'b0, 16'h0,    1'b1, 32'h0000_6969, 1'b0};
        vecs[8]  = '{1'b0, 2'd0, 32'h0,    1'b1, 16'h1234, 1'b1, 32'h0000_1234, 1'b1};
        vecs[9]  = '{1'b0, 2'd0, 32'h0,    1'b1, 16'h1234, 1'b0, 32'h0000_1234, 1'b1};
        vecs[10] = '{1'b0, 2'd0, 32'h0,    1'b1, 16'h4321, 1'b1, 32'h0000_4321, 1'b1};
        vecs[11] = '{1'b0, 2'd0, 32'h0,    1'b1, 16'h4321, 1'b0, 32'h0000_4321, 1'b1};
        vecs[12] = '{1'b1, 2'd0, 32'h00FF, 1'b1, 16'h4321, 1'b0, 32'h0000_4321, 1'b1};
        vecs[13] = '{1'b0, 2'd0, 32'h0,    1'b0, 16'h4321, 1'b1, 32'h0000_00FF, 1'b0};
        vecs[14] = '{1'b0, 2'd0, 32'h0,    1'b0, 16'h0,    1'b1, 32'h0000_807F, 1'b0};
        vecs[15] = '{1'b1, 2'd1, 32'h0,    1'b0, 16'h0,    1'b1, 32'h0000_00FF, 1'b0};
        vecs[16] = '{1'b0, 2'd0, 32'h0,    1'b0, 16'h0,    1'b0, 32'h0000_00FF, 1'b0};

        // Reset state, then first cycle after release
        bus.cpu_wr = 1'b0;
        bus.cpu_addr = 2'd0;
        bus.cpu_writedata = '0;
        bus.hw_req = 1'b0;
        bus.hw_pattern = '0;
        idle(2);
        check("rst_gnt", {31'b0, bus.hw_gnt}, 32'd0);
        check("rst_wr", {31'b0, bus.led_wr}, 32'd0);
        check("rst_data", bus.led_writedata, 32'h0);
        @(negedge clock) reset_n = 1'b1;
        idle(1);
        check("rel_wr", {31'b0, bus.led_wr}, 32'd0);

        // Vector table
        for (int i = 0; i < 17; i++) begin
            bus.cpu_wr = vecs[i].wr;
            bus.cpu_addr = vecs[i].addr;
            bus.cpu_writedata = vecs[i].wdata;
            bus.hw_req = vecs[i].hreq;
            bus.hw_pattern = vecs[i].hpat;
            idle(1);
            check($sformatf("v%0d_wr", i), {31'b0, bus.led_wr}, {31'b0, vecs[i].ewr});
            check($sformatf("v%0d_data", i), bus.led_writedata, vecs[i].edata);
            check($sformatf("v%0d_gnt", i), {31'b0, bus.hw_gnt}, {31'b0, vecs[i].egnt});
        end
        bus.cpu_wr = 1'b0;

        // STATIC pattern: single pulse, then quiet for 100 cycles
        do_reset();
        pq.delete();
        rec = 1'b1;
        cw = cyc;
        cpu_write(ADDR_PATTERN, 32'hA5A5);
        idle(100);
        check("static_cnt", pq.size(), 32'd1);
        check("static_data", pd(0), 32'h0000_A5A5);
        check("static_lat", pc(0) - cw, 32'd1);

        // SHIFT_L with DIV=3: 4-cycle spacing, wraps after 16 ticks
        do_reset();
        cpu_write(ADDR_PATTERN, 32'h0001);
        cpu_write(ADDR_DIV, 32'd3);
        pq.delete();
        cpu_write(ADDR_MODE, 32'(MODE_SHIFT_L));
        idle(70);
        check("shl_d0", pd(0), 32'h0001);
        check("shl_d1", pd(1), 32'h0002);
        check("shl_d2", pd(2), 32'h0004);
        check("shl_d3", pd(3), 32'h0008);
        check("shl_gap1", pc(1) - pc(0), 32'd4);
        check("shl_gap2", pc(2) - pc(1), 32'd4);
        check("shl_wrap", pd(16), 32'h0001);
        check("shl_wrap_t", pc(16) - pc(0), 32'd64);

        // BLINK with DIV=1: alternate every 2 cycles
        do_reset();
        cpu_write(ADDR_PATTERN, 32'hFFFF);
        cpu_write(ADDR_DIV, 32'd1);
        pq.delete();
        cpu_write(ADDR_MODE, 32'(MODE_BLINK));
        idle(12);
        check("blk_d0", pd(0), 32'hFFFF);
        check("blk_d1", pd(1), 32'h0000);
        check("blk_d2", pd(2), 32'hFFFF);
        check("blk_d3", pd(3), 32'h0000);
        check("blk_gap1", pc(1) - pc(0), 32'd2);
        check("blk_gap2", pc(2) - pc(1), 32'd2);
        check("blk_pre_rst", bus.led_writedata, 32'hFFFF);

        // Async reset mid-blink, no pulse after release
        reset_n = 1'b0;
        #1;
        check("arst_wr", {31'b0, bus.led_wr}, 32'd0);
        check("arst_data", bus.led_writedata, 32'h0);
        check("arst_gnt", {31'b0, bus.hw_gnt}, 32'd0);
        pq.delete();
        @(negedge clock) reset_n = 1'b1;
        idle(6);
        check("arst_quiet", pq.size(), 32'd0);

        // hw_req and PATTERN write in the same cycle: HW wins, PATTERN kept
        do_reset();
        bus.hw_req = 1'b1;
        bus.hw_pattern = 16'h5555;
        cpu_write(ADDR_PATTERN, 32'h00FF);
        check("pri_wr", {31'b0, bus.led_wr}, 32'd1);
        check("pri_data", bus.led_writedata, 32'h5555);
        check("pri_gnt", {31'b0, bus.hw_gnt}, 32'd1);
        idle(1);
        check("pri_hold", {31'b0, bus.led_wr}, 32'd0);
        bus.hw_req = 1'b0;
        idle(1);
        check("pri_rel_wr", {31'b0, bus.led_wr}, 32'd1);
        check("pri_rel_data", bus.led_writedata, 32'h00FF);
        check("pri_rel_gnt", {31'b0, bus.hw_gnt}, 32'd0);

        rec = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/led_sequencer.md
LED_SEQUENCER -- requirements
Module: led_sequencer

Interface
REQ-001 SHALL have parameter Dbits, default 32, width of CPU write data and LED write data.
REQ-002 SHALL have parameter DIV_W, default 26, width of the prescaler divider register.
REQ-003 SHALL have port clock, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1; reset is asynchronous and active-low.
REQ-005 SHALL have port cpu_wr, input, 1, CPU register-write strobe, one cycle per write.
REQ-006 SHALL have port cpu_addr, input, 2, register select: 0 PATTERN, 1 MODE, 2 DIV, 3 reserved.
REQ-007 SHALL have port cpu_writedata, input, Dbits, CPU write data.
REQ-008 SHALL have port hw_req, input, 1, hardware requester (maze status) asks to own the LEDs.
REQ-009 SHALL have port hw_pattern, input, 16, LED value supplied by the hardware requester.
REQ-010 SHALL have port hw_gnt, output, 1, high while the hardware requester owns the LEDs.
REQ-011 SHALL have port led_wr, output, 1, one-cycle write strobe to the LED register.
REQ-012 SHALL have port led_writedata, output, Dbits, LED value; bits [Dbits-1:16] always 0.

Function
REQ-013 SHALL hold registers PATTERN[15:0], MODE[1:0] (0 STATIC, 1 BLINK, 2 SHIFT_L, 3 SHIFT_R), DIV[DIV_W-1:0], and an internal current value CUR[15:0].
REQ-014 SHALL accept every CPU write in the cycle cpu_wr=1, regardless of state; writes to address 3 are ignored.
REQ-015 SHALL use a prescaler that reloads DIV and counts down to 0, emitting a one-cycle tick at 0, giving a period of DIV+1 cycles (DIV=0: tick every cycle).
REQ-016 SHALL reload the prescaler and clear the blink phase on any write to MODE, DIV or PATTERN.
REQ-017 SHALL implement states ANIM and HW; HW is entered in the cycle after hw_req rises and is left in the cycle after hw_req falls.
REQ-018 SHALL assert hw_gnt exactly while in HW; in HW, led_wr pulses whenever hw_pattern differs from CUR, and on HW entry, with CUR and led_writedata set to hw_pattern.
REQ-019 SHALL, in ANIM on a PATTERN or MODE write, set CUR to PATTERN (new value) and pulse led_wr in the next cycle.
REQ-020 SHALL, in ANIM on a tick: STATIC no action; BLINK alternate output between 16'h0000 and CUR; SHIFT_L rotate CUR left by 1; SHIFT_R rotate CUR right by 1; each change pulses led_wr.
REQ-021 SHALL, on HW exit, restore CUR to PATTERN, reload the prescaler and pulse led_wr with PATTERN in the next cycle.
REQ-022 SHALL, while in HW, update registers from CPU writes without pulsing led_wr; the prescaler is held at reload.
REQ-023 SHALL give hw_req priority when hw_req and a CPU write occur in the same cycle: the register updates, and HW ownership follows REQ-018.
REQ-024 SHALL change led_writedata only in cycles where led_wr=1.

Reset
REQ-025 SHALL, while reset_n=0, force PATTERN=0, MODE=STATIC, DIV=0, CUR=0, state ANIM, prescaler at 0, hw_gnt=0, led_wr=0, led_writedata=0.
REQ-026 SHALL NOT pulse led_wr in the first cycle after reset release; reset mid-operation abandons any HW ownership immediately.

Structure
REQ-027 SHALL place the mode encoding, register address constants and state enum in shared package led_pkg.
REQ-028 SHALL implement the down-counter with reload and tick in a sub-module led_prescaler, parameterised by DIV_W.

Verification
REQ-029 SHALL verify: reset, write PATTERN=16'hA5A5 (MODE STATIC) -> led_wr pulses once next cycle, led_writedata=32'h0000A5A5, no further pulses for 100 cycles.
REQ-030 SHALL verify: PATTERN=16'h0001, DIV=3, MODE=SHIFT_L -> led_writedata 0x0001, 0x0002, 0x0004 at 4-cycle spacing; after 16 ticks the value wraps back to 0x0001.
REQ-031 SHALL verify: PATTERN=16'hFFFF, DIV=1, MODE=BLINK -> outputs alternate 0x0000/0xFFFF every 2 cycles.
REQ-032 SHALL verify: during SHIFT_R, assert hw_req with hw_pattern=16'h1234 -> hw_gnt=1 the next cycle and led_writedata=0x1234; change hw_pattern to 16'h4321 -> one led_wr; deassert -> PATTERN restored, hw_gnt=0.
REQ-033 SHALL verify: hw_req asserted and a PATTERN=16'h00FF write in the same cycle -> HW output wins; after release, led_writedata=0x00FF.
REQ-034 SHALL verify: reset_n pulsed low mid-blink -> all outputs 0 asynchronously, and no led_wr on release.
